// File: rtl/mode_seq_pkg.sv
// rtl/mode_seq_pkg.sv - shared state encodings and print string selects for the mode sequencer
package mode_seq_pkg;

  localparam int MODE_W = 3;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] STR_NONE      = 4'd0;
  localparam logic [SEL_W-1:0] STR_INTRO     = 4'd1;
  localparam logic [SEL_W-1:0] STR_INVALID   = 4'd2;
  localparam logic [SEL_W-1:0] STR_REPORT    = 4'd3;
  localparam logic [SEL_W-1:0] STR_TIMEOUT   = 4'd4;
  localparam logic [SEL_W-1:0] STR_MODE_BASE = 4'd8;

  typedef enum logic [2:0] {
    ST_BANNER,
    ST_IDLE,
    ST_ANNOUNCE,
    ST_EXEC,
    ST_REPORT,
    ST_INVALID,
    ST_TIMEOUT
  } state_e;

  // String owned by a state; STR_NONE means the state does not print.
  function automatic logic [SEL_W-1:0] str_for_state(input state_e st, input logic [MODE_W-1:0] mode);
    logic [SEL_W-1:0] s;
    s = STR_NONE;
    case (st)
      ST_BANNER:   s = STR_INTRO;
      ST_ANNOUNCE: s = STR_MODE_BASE | {1'b0, mode};
      ST_REPORT:   s = STR_REPORT;
      ST_INVALID:  s = STR_INVALID;
      ST_TIMEOUT:  s = STR_TIMEOUT;
      default:     s = STR_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mode_seq_watchdog.sv
// rtl/mode_seq_watchdog.sv - EXEC-phase cycle counter, used only with MODE_SEQ_WATCHDOG_EN
module mode_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic expired_o
);

  localparam logic [23:0] LIMIT = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] cnt_q, cnt_d;

  // Held at zero outside EXEC, so the first EXEC cycle always sees a count of 0.
  always_comb begin
    cnt_d = '0;
    if (run_i) cnt_d = cnt_q + 24'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = run_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - command-driven mode sequencer with print handshakes
// Optional watchdog on the EXEC phase when MODE_SEQ_WATCHDOG_EN is defined.
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int          NUM_MODES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid_i,
  input  logic [MODE_W-1:0]    cmd_code_i,
  output logic                 cmd_ready_o,
  output logic [NUM_MODES-1:0] exec_start_o,
  input  logic [NUM_MODES-1:0] exec_done_i,
  output logic [NUM_MODES-1:0] exec_abort_o,
  output logic                 print_req_o,
  output logic [SEL_W-1:0]     print_sel_o,
  input  logic                 print_done_i,
  output logic [MODE_W-1:0]    cur_mode_o,
  output logic                 busy_o,
  output logic                 err_timeout_o
);

  localparam logic [3:0] NUM_MODES_W = 4'(NUM_MODES);

  if (NUM_MODES < 2 || NUM_MODES > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32'hFFFFFF) begin : g_bad_params
    $error("mode_sequencer: parameter out of range");
  end

  state_e                 state_q, state_d;
  logic [MODE_W-1:0]      cur_mode_q, cur_mode_d;
  logic                   print_req_q, print_req_d;
  logic [SEL_W-1:0]       print_sel_q, print_sel_d;
  logic [NUM_MODES-1:0]   exec_start_q, exec_start_d;
  logic                   err_q, err_d;

  logic                   accept, cmd_ok, mode_done, wd_expired;
  logic [NUM_MODES-1:0]   mode_onehot;

  assign accept      = cmd_valid_i && (state_q == ST_IDLE);
  assign cmd_ok      = {1'b0, cmd_code_i} < NUM_MODES_W;
  assign mode_onehot = {{(NUM_MODES-1){1'b0}}, 1'b1} << cur_mode_q;
  assign mode_done   = |(exec_done_i & mode_onehot);

`ifdef MODE_SEQ_WATCHDOG_EN
  mode_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (state_q == ST_EXEC),
    .expired_o (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    err_d      = err_q;
    case (state_q)
      ST_BANNER:   if (print_done_i) state_d = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          if (cmd_ok) begin
            state_d    = ST_ANNOUNCE;
            cur_mode_d = cmd_code_i;
            err_d      = 1'b0;
          end else begin
            state_d = ST_INVALID;
          end
        end
      end
      ST_ANNOUNCE: if (print_done_i) state_d = ST_EXEC;
      ST_EXEC: begin
        // Completion in the expiry cycle takes priority over the timeout.
        if (mode_done) begin
          state_d = ST_REPORT;
        end else if (wd_expired) begin
          state_d = ST_TIMEOUT;
          err_d   = 1'b1;
        end
      end
      ST_REPORT, ST_INVALID, ST_TIMEOUT: if (print_done_i) state_d = ST_IDLE;
      default:     state_d = ST_BANNER;
    endcase

    // Print outputs are registered from the next state so they appear the
    // cycle after a transition and stay constant until print_done.
    print_sel_d  = str_for_state(state_d, cur_mode_d);
    print_req_d  = (print_sel_d != STR_NONE);
    exec_start_d = ((state_d == ST_EXEC) && (state_q != ST_EXEC)) ? mode_onehot : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BANNER;
      cur_mode_q   <= '0;
      err_q        <= 1'b0;
      print_req_q  <= 1'b0;
      print_sel_q  <= STR_NONE;
      exec_start_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_mode_q   <= cur_mode_d;
      err_q        <= err_d;
      print_req_q  <= print_req_d;
      print_sel_q  <= print_sel_d;
      exec_start_q <= exec_start_d;
    end
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign exec_start_o  = exec_start_q;
  assign exec_abort_o  = (wd_expired && !mode_done) ? mode_onehot : '0;
  assign print_req_o   = print_req_q;
  assign print_sel_o   = print_sel_q;
  assign cur_mode_o    = cur_mode_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - randomized self-checking bench for mode_sequencer (watchdog case under MODE_SEQ_WATCHDOG_EN)
module tb_mode_sequencer;

  localparam int NM = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_code = 3'd0;
  logic          cmd_ready;
  logic [NM-1:0] exec_start;
  logic [NM-1:0] exec_done = '0;
  logic [NM-1:0] exec_abort;
  logic          print_req;
  logic [3:0]    print_sel;
  logic          print_done = 1'b0;
  logic [2:0]    cur_mode;
  logic          busy;
  logic          err_timeout;

  int errors = 0;
  int checks = 0;

  // Reference expectations derived from the command history.
  logic [2:0] exp_mode = 3'd0;
  logic       exp_err  = 1'b0;

  mode_sequencer #(.NUM_MODES(NM), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_code_i    (cmd_code),
    .cmd_ready_o   (cmd_ready),
    .exec_start_o  (exec_start),
    .exec_done_i   (exec_done),
    .exec_abort_o  (exec_abort),
    .print_req_o   (print_req),
    .print_sel_o   (print_sel),
    .print_done_i  (print_done),
    .cur_mode_o    (cur_mode),
    .busy_o        (busy),
    .err_timeout_o (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NM-1:0] onehot(input logic [2:0] m);
    logic [NM-1:0] v;
    v = '0;
    v[m[1:0]] = 1'b1;
    return v;
  endfunction

  function automatic logic [NM-1:0] noise_without(input logic [2:0] m);
    logic [NM-1:0] v;
    v = NM'($urandom);
    if (m < NM) v[m[1:0]] = 1'b0;
    return v;
  endfunction

  // Waits a bounded number of cycles for a print request to appear.
  task automatic wait_req(input string tag);
    int n = 0;
    while (print_req !== 1'b1 && n < 8) begin
      chk({tag, "_nostart"}, exec_start, 0);
      tick();
      n++;
    end
    chk({tag, "_req"}, print_req, 1);
  endtask

  // Holds the printer busy for a random time, then completes the string.
  task automatic print_hs(input logic [3:0] exp_sel, input string tag);
    int hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_req"}, print_req, 1);
      chk({tag, "_hold_sel"}, print_sel, exp_sel);
      chk({tag, "_hold_rdy"}, cmd_ready, 0);
      chk({tag, "_hold_start"}, exec_start, 0);
      tick();
    end
    chk({tag, "_done_req"}, print_req, 1);
    chk({tag, "_done_sel"}, print_sel, exp_sel);
    print_done = 1'b1;
    tick();
    print_done = 1'b0;
  endtask

  task automatic accept_cmd(input logic [2:0] c, input string tag);
    chk({tag, "_idle_rdy"}, cmd_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    cmd_valid  = 1'b1;
    cmd_code   = c;
    exec_done  = NM'($urandom);
    print_done = 1'($urandom);
    tick();
    cmd_valid  = 1'b0;
    exec_done  = '0;
    print_done = 1'b0;
    if (c < NM) begin
      exp_mode = c;
      exp_err  = 1'b0;
    end
    chk({tag, "_acc_req"}, print_req, 1);
    chk({tag, "_acc_sel"}, print_sel, (c < NM) ? 8 + c : 2);
    chk({tag, "_acc_mode"}, cur_mode, exp_mode);
    chk({tag, "_acc_err"}, err_timeout, exp_err);
    chk({tag, "_acc_rdy"}, cmd_ready, 0);
  endtask

  // Full command: announce, execute with d noise cycles, report.
  task automatic run_cmd(input logic [2:0] c, input int d, input bit force0, input logic [NM-1:0] noise0, input string tag);
    accept_cmd(c, tag);
    if (c < NM) begin
      print_hs(4'(8 + c), {tag, "_ann"});
      chk({tag, "_start"}, exec_start, onehot(c));
      chk({tag, "_exec_req"}, print_req, 0);
      for (int j = 0; j < d; j++) begin
        exec_done  = (force0 && j == 0) ? noise0 : noise_without(c);
        print_done = 1'($urandom);
        cmd_valid  = 1'($urandom);
        cmd_code   = 3'($urandom);
        #1;
        chk({tag, "_exec_abort"}, exec_abort, 0);
        tick();
        chk({tag, "_exec_start0"}, exec_start, 0);
        chk({tag, "_exec_busy"}, busy, 1);
        chk({tag, "_exec_noreq"}, print_req, 0);
      end
      exec_done  = onehot(c) | noise_without(c);
      print_done = 1'b0;
      cmd_valid  = 1'b1;
      cmd_code   = 3'($urandom);
      tick();
      exec_done  = '0;
      cmd_valid  = 1'b0;
      chk({tag, "_rep_req"}, print_req, 1);
      chk({tag, "_rep_sel"}, print_sel, 3);
      chk({tag, "_rep_rdy"}, cmd_ready, 0);
      print_hs(4'd3, {tag, "_rep"});
    end else begin
      print_hs(4'd2, {tag, "_inv"});
    end
    chk({tag, "_end_rdy"}, cmd_ready, 1);
    chk({tag, "_end_mode"}, cur_mode, exp_mode);
    chk({tag, "_end_err"}, err_timeout, exp_err);
    chk({tag, "_end_start"}, exec_start, 0);
  endtask

  // Enters EXEC for mode m and lets TO cycles pass; done_last finishes in the expiry cycle.
  task automatic long_exec(input logic [2:0] m, input bit done_last, input string tag);
    accept_cmd(m, tag);
    print_hs(4'(8 + m), {tag, "_ann"});
    chk({tag, "_start"}, exec_start, onehot(m));
    for (int k = 1; k <= TO; k++) begin
      exec_done = (done_last && k == TO) ? onehot(m) : noise_without(m);
      #1;
`ifdef MODE_SEQ_WATCHDOG_EN
      chk({tag, "_abort"}, exec_abort, (k == TO && !done_last) ? onehot(m) : 0);
`else
      chk({tag, "_abort"}, exec_abort, 0);
`endif
      if (k < TO) begin
        tick();
        chk({tag, "_in_exec"}, print_req, 0);
      end
    end
    tick();
    exec_done = '0;
`ifdef MODE_SEQ_WATCHDOG_EN
    if (!done_last) begin
      exp_err = 1'b1;
      chk({tag, "_abort_gone"}, exec_abort, 0);
      chk({tag, "_to_err"}, err_timeout, 1);
      chk({tag, "_to_req"}, print_req, 1);
      chk({tag, "_to_sel"}, print_sel, 4);
      print_hs(4'd4, {tag, "_to"});
    end else begin
      chk({tag, "_win_err"}, err_timeout, 0);
      chk({tag, "_win_sel"}, print_sel, 3);
      print_hs(4'd3, {tag, "_win"});
    end
`else
    if (!done_last) begin
      for (int k = 0; k < 24; k++) begin
        chk({tag, "_wait_abort"}, exec_abort, 0);
        chk({tag, "_wait_err"}, err_timeout, 0);
        chk({tag, "_wait_req"}, print_req, 0);
        tick();
      end
      exec_done = onehot(m);
      tick();
      exec_done = '0;
    end
    chk({tag, "_rep_sel"}, print_sel, 3);
    print_hs(4'd3, {tag, "_rep"});
`endif
    chk({tag, "_end_rdy"}, cmd_ready, 1);
    chk({tag, "_end_err"}, err_timeout, exp_err);
  endtask

  initial begin
    #3;
    chk("rst_rdy", cmd_ready, 0);
    chk("rst_start", exec_start, 0);
    chk("rst_abort", exec_abort, 0);
    chk("rst_req", print_req, 0);
    chk("rst_sel", print_sel, 0);
    chk("rst_mode", cur_mode, 0);
    chk("rst_err", err_timeout, 0);

    tick();
    rst_n = 1'b1;
    wait_req("banner");
    chk("banner_sel", print_sel, 1);
    print_hs(4'd1, "banner");
    chk("banner_rdy", cmd_ready, 1);
    chk("banner_req_off", print_req, 0);

    run_cmd(3'd2, 2, 1'b0, '0, "mode2");
    run_cmd(3'd5, 0, 1'b0, '0, "bad5");
    run_cmd(3'd1, 1, 1'b1, 4'b0001, "mode1");

    long_exec(3'd3, 1'b0, "wd_expire");
    run_cmd(3'd0, 1, 1'b0, '0, "after_to");
    long_exec(3'd1, 1'b1, "wd_race");

    for (int t = 0; t < 24; t++) begin
      run_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 5), 1'b0, '0, "rand");
    end

    accept_cmd(3'd3, "rst_ann");
    #2;
    rst_n = 1'b0;
    #1;
    exp_mode = 3'd0;
    exp_err  = 1'b0;
    chk("midrst_req", print_req, 0);
    chk("midrst_sel", print_sel, 0);
    chk("midrst_mode", cur_mode, 0);
    chk("midrst_rdy", cmd_ready, 0);
    chk("midrst_start", exec_start, 0);
    chk("midrst_abort", exec_abort, 0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_req("rebanner");
    chk("rebanner_sel", print_sel, 1);
    print_hs(4'd1, "rebanner");
    chk("rebanner_rdy", cmd_ready, 1);
    chk("rebanner_mode", cur_mode, exp_mode);
    chk("rebanner_start", exec_start, 0);

    run_cmd(3'd3, 3, 1'b0, '0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
